// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, FSM states and byte-enable constants for mem_access_unit
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack data-memory port between mem_access_unit and memory
interface mem_access_unit_if;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );

endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select and sign/zero extension of the returned memory word
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (a_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_HALF: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit; optional misaligned trap via MEM_MISALIGN_EXC_EN
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memreadM,
  input  logic                     memwriteM,
  input  logic [1:0]               mem_sizeM,
  input  logic                     mem_unsignedM,
  input  logic [31:0]              alu_outM,
  input  logic [31:0]              write_dataM,
  output logic                     stallM,
  output logic [31:0]              dm_outM,
  output logic                     dm_errM,
  output logic                     misalignedM,
  mem_access_unit_if.master        dm
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d, mis_q, mis_d, uns_q, uns_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, out_q, out_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  size_q, size_d, a_q, a_d;
  logic        mem_op, mis_op;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, load_data;
  logic [1:0]  a;

  mem_load_align u_load_align (
    .rdata_i    (dm.dm_rdata),
    .a_i        (a_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_comb begin
    a = alu_outM[1:0];
    case (mem_sizeM)
      SZ_BYTE: begin be_n = 4'b0001 << a; wdata_n = {4{write_dataM[7:0]}}; end
      SZ_HALF: begin be_n = a[1] ? BE_HALF_HI : BE_HALF_LO; wdata_n = {2{write_dataM[15:0]}}; end
      default: begin be_n = BE_WORD; wdata_n = write_dataM; end
    endcase
`ifdef MEM_MISALIGN_EXC_EN
    mis_op = ((mem_sizeM == SZ_HALF) && a[0]) || (mem_sizeM[1] && (a != 2'b00));
`else
    mis_op = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    size_d  = size_q;
    a_d     = a_q;
    uns_d   = uns_q;
    stallM  = 1'b0;
    mem_op  = memreadM | memwriteM;
    case (state_q)
      IDLE: begin
        stallM = mem_op;
        if (mem_op) begin
          we_d    = memwriteM;
          addr_d  = {alu_outM[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          size_d  = mem_sizeM;
          a_d     = a;
          uns_d   = mem_unsignedM;
          cnt_d   = 16'd0;
          if (mis_op) begin
            mis_d   = 1'b1;
            out_d   = 32'd0;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (dm.dm_ack) begin
          if (!we_q) out_d = load_data;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          out_d   = 32'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      out_q   <= 32'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 16'd0;
      size_q  <= 2'd0;
      a_q     <= 2'd0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      a_q     <= a_d;
      uns_q   <= uns_d;
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = wdata_q;
  assign dm_outM     = out_q;
  assign dm_errM     = err_q;
  assign misalignedM = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a behavioural model
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memreadM = 1'b0, memwriteM = 1'b0, mem_unsignedM = 1'b0;
  logic [1:0]  mem_sizeM = 2'b00;
  logic [31:0] alu_outM = 32'd0, write_dataM = 32'd0;
  logic        stallM, dm_errM, misalignedM;
  logic [31:0] dm_outM;
  logic [31:0] exp_out = 32'd0;
  int          tests = 0, fails = 0;

  mem_access_unit_if dmif ();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .memreadM      (memreadM),
    .memwriteM     (memwriteM),
    .mem_sizeM     (mem_sizeM),
    .mem_unsignedM (mem_unsignedM),
    .alu_outM      (alu_outM),
    .write_dataM   (write_dataM),
    .stallM        (stallM),
    .dm_outM       (dm_outM),
    .dm_errM       (dm_errM),
    .misalignedM   (misalignedM),
    .dm            (dmif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int addr, input int sz, input bit uns);
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input int addr, input int sz);
    if (sz == 0) return 4'(1 << (addr % 4));
    if (sz == 1) return 4'(3 << (2 * ((addr / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wd, input int sz);
    if (sz == 0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic bit m_mis(input int addr, input int sz);
`ifdef MEM_MISALIGN_EXC_EN
    return (sz == 1 && (addr % 2) != 0) || (sz >= 2 && (addr % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Called one step after a rising edge with the DUT idle; returns with the DUT idle again.
  task automatic do_op(input bit st, input int sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input int delay, input logic [31:0] rd);
    int stalls = 0, reqs = 0, exp_reqs;
    bit mis, tmo;
    mis = m_mis(int'(addr[1:0]), sz);
    tmo = !mis && delay >= TMO;
    exp_reqs = mis ? 0 : (tmo ? TMO : delay + 1);
    memwriteM = st; memreadM = st ? 1'($urandom % 2) : 1'b1;
    mem_sizeM = 2'(sz); mem_unsignedM = uns; alu_outM = addr; write_dataM = wd;
    #1;
    while (stallM && stalls < 50) begin
      if (dmif.dm_req) begin
        if (reqs == 0) begin
          chk("req_addr", dmif.dm_addr, {addr[31:2], 2'b00});
          chk("req_be", 32'(dmif.dm_be), 32'(m_be(int'(addr[1:0]), sz)));
          chk("req_wdata", dmif.dm_wdata, m_wd(wd, sz));
          chk("req_we", 32'(dmif.dm_we), 32'(st));
        end
        dmif.dm_ack = (reqs == delay);
        dmif.dm_rdata = (reqs == delay) ? rd : $urandom;
        reqs++;
      end else begin
        dmif.dm_ack = 1'($urandom % 2);
        dmif.dm_rdata = $urandom;
      end
      stalls++;
      @(posedge clk); #1;
    end
    dmif.dm_ack = 1'b0;
    if (mis || tmo) exp_out = 32'd0;
    else if (!st) exp_out = m_load(rd, int'(addr[1:0]), sz, uns);
    chk("stall_cycles", 32'(stalls), 32'(1 + exp_reqs));
    chk("req_cycles", 32'(reqs), 32'(exp_reqs));
    chk("done_out", dm_outM, exp_out);
    chk("done_err", 32'(dm_errM), 32'(tmo));
    chk("done_mis", 32'(misalignedM), 32'(mis));
    chk("done_req", 32'(dmif.dm_req), 32'd0);
    memreadM = 1'b0; memwriteM = 1'b0;
    @(posedge clk); #1;
    chk("idle_err", 32'(dm_errM), 32'd0);
  endtask

  initial begin
    dmif.dm_ack = 1'b0;
    dmif.dm_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_req", 32'(dmif.dm_req), 32'd0);
    chk("rst_we", 32'(dmif.dm_we), 32'd0);
    chk("rst_addr", dmif.dm_addr, 32'd0);
    chk("rst_be", 32'(dmif.dm_be), 32'd0);
    chk("rst_wdata", dmif.dm_wdata, 32'd0);
    chk("rst_out", dm_outM, 32'd0);
    chk("rst_err", 32'(dm_errM), 32'd0);
    chk("rst_mis", 32'(misalignedM), 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);

    do_op(1'b0, 2, 1'b0, 32'h100, 32'd0, 0, 32'hDEADBEEF);
    chk("lw_const", dm_outM, 32'hDEADBEEF);
    do_op(1'b0, 0, 1'b0, 32'h103, 32'd0, 1, 32'h80FF1234);
    chk("lb_const", dm_outM, 32'hFFFFFF80);
    do_op(1'b0, 0, 1'b1, 32'h103, 32'd0, 0, 32'h80FF1234);
    chk("lbu_const", dm_outM, 32'h00000080);
    do_op(1'b0, 1, 1'b0, 32'h102, 32'd0, 2, 32'h80FF1234);
    chk("lh_const", dm_outM, 32'hFFFF80FF);
    do_op(1'b1, 0, 1'b0, 32'h101, 32'h000000A5, 0, 32'd0);
    chk("sb_keeps_out", dm_outM, 32'hFFFF80FF);
    do_op(1'b1, 1, 1'b0, 32'h102, 32'h00001234, 1, 32'd0);
    do_op(1'b0, 2, 1'b0, 32'h200, 32'd0, 9, 32'h12345678);
    chk("tmo_out", dm_outM, 32'd0);
    do_op(1'b0, 2, 1'b0, 32'h204, 32'd0, 0, 32'hCAFEF00D);

    memreadM = 1'b1; mem_sizeM = 2'd2; alu_outM = 32'h300;
    @(posedge clk); #1;
    chk("rst_mid_req_on", 32'(dmif.dm_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(dmif.dm_req), 32'd0);
    chk("rst_mid_out", dm_outM, 32'd0);
    memreadM = 1'b0;
    @(negedge clk); reset = 1'b1;
    dmif.dm_ack = 1'b1; dmif.dm_rdata = 32'h55AA55AA;
    repeat (2) begin @(posedge clk); #1; end
    dmif.dm_ack = 1'b0;
    chk("late_ack_out", dm_outM, 32'd0);
    chk("late_ack_req", 32'(dmif.dm_req), 32'd0);
    chk("late_ack_stall", 32'(stallM), 32'd0);
    chk("late_ack_addr", dmif.dm_addr, 32'd0);
    exp_out = 32'd0;

    do_op(1'b0, 2, 1'b0, 32'h102, 32'd0, 0, 32'hA1B2C3D4);
`ifndef MEM_MISALIGN_EXC_EN
    chk("lw_unaligned_val", dm_outM, 32'hA1B2C3D4);
`endif

    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom % 2), int'($urandom % 4), 1'($urandom % 2), $urandom,
            $urandom, int'($urandom % 6), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the five-stage MIPS pipeline, between the EX/MEM pipeline register and MemToWb. Turns a memory instruction in M into one request on a req/ack data-memory port and generates byte enables and write-lane replication. Sign- or zero-extends load data into `dm_outM` and stalls the pipeline until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 255: max REQ cycles without `dm_ack` before abort (1..65535).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memreadM` in 1: load in M.
- `memwriteM` in 1: store in M; wins over `memreadM` if both high.
- `mem_sizeM` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_unsignedM` in 1: zero-extend load (lbu/lhu), else sign-extend.
- `alu_outM` in 32: effective byte address.
- `write_dataM` in 32: store data, right-justified.
- `stallM` out 1: freeze PC, IF/ID, ID/EX, EX/MEM and MemToWb.
- `dm_outM` out 32: extended load result, registered.
- `dm_errM` out 1: access timed out; one-cycle pulse in DONE.
- `misalignedM` out 1: misaligned-access flag (see Configuration).
- `dm_req` out 1, `dm_we` out 1, `dm_addr` out 32 (bits[1:0]=0), `dm_be` out 4, `dm_wdata` out 32: memory request, all registered.
- `dm_ack` in 1, `dm_rdata` in 32: memory completion and read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: `stallM` = `memreadM|memwriteM` (combinational). With a memory op, register `dm_addr`/`dm_be`/`dm_wdata`/`dm_we`, clear timeout counter, go REQ.
- REQ: `dm_req`=1, request fields held stable, `stallM`=1.
  - `dm_ack`=1: for loads, capture extended `dm_rdata` into `dm_outM`; go DONE.
  - Otherwise increment counter. At `TIMEOUT_CYCLES` go DONE with `dm_errM`=1 and `dm_outM`=0.
- DONE: `dm_req`=0, `stallM`=0, `dm_outM` valid. MemToWb captures at this edge. Always go IDLE.
- Stores leave `dm_outM` unchanged.
- Byte enables from address bits a=`alu_outM[1:0]`:
  - byte: be=1<<a, wdata={4{wd[7:0]}}.
  - half: be=a[1]?1100:0011, wdata={2{wd[15:0]}}.
  - word: be=1111, wdata=wd.
- Load extract: select lane by a (byte) or a[1] (half); extend to 32 bits per `mem_unsignedM`. Word passes through.
- `dm_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `dm_req`, `dm_we`, `dm_addr`, `dm_be`, `dm_wdata`, `dm_outM`, `dm_errM`, `misalignedM` all 0.
- Minimum latency (ack in first REQ cycle):
  - cycle N IDLE, stall=1.
  - N+1 REQ, ack sampled.
  - N+2 DONE, stall=0.
- Total stall cycles = 1 + number of REQ cycles.
- Back-to-back memory ops: DONE→IDLE; the next op is seen in IDLE the following cycle. No op is issued twice.
- Reset mid-REQ: `dm_req` drops asynchronously, no result is produced, any late ack is ignored.

## Configuration
- `MEM_MISALIGN_EXC_EN` defined:
  - Misaligned = half with a[0]=1, or word with a≠0.
  - A misaligned op goes IDLE→DONE directly with no request.
  - In DONE: `misalignedM`=1, `dm_outM`=0, total stall 1 cycle.
- Undefined: `misalignedM` tied 0. Half ignores a[0]; word ignores a[1:0]. Access proceeds aligned.

## Structure
- Package `mem_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, BE constants (BE_WORD=4'b1111, BE_HALF_LO/HI).
- Sub-module `mem_load_align`: combinational lane select plus extension (inputs rdata, a, size, unsigned; output 32-bit). Instantiated once.

## Test plan
- Word load 0x100, rdata 0xDEADBEEF, ack in first REQ cycle → `dm_outM`=0xDEADBEEF, stall exactly 2 cycles, `dm_be`=1111.
- lb at 0x103, rdata 0x80FF1234 → 0xFFFFFF80. lbu → 0x00000080. lh at 0x102 → 0xFFFF80FF.
- sb 0x000000A5 at 0x101 → `dm_be`=0010, `dm_wdata`=0xA5A5A5A5, `dm_we`=1. sh at 0x102 → `dm_be`=1100.
- Ack withheld, `TIMEOUT_CYCLES`=4 → 4 REQ cycles, then DONE with `dm_errM`=1, `dm_outM`=0, `dm_req`=0.
- Reset asserted in REQ, late ack after release → all outputs 0, state IDLE, no `dm_outM` update.
- With `MEM_MISALIGN_EXC_EN`, lw at 0x102 → no `dm_req`, `misalignedM`=1 for one cycle, stall 1 cycle. Without the macro → `dm_addr`=0x100, normal load.
